// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline types and widths for the memory stage
// Ports: none (package). Holds the MEM FSM state encoding and datapath widths.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_latch.sv
// rtl/mem_wb_latch.sv - MEM/WB pipeline register with load enable and bubble insertion
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              capture data/rd/we; when low a bubble (we = 0) is inserted
//   data, rd, we      next writeback values
//   wb_data, wb_rd, wb_we  registered writeback values
module mem_wb_latch
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic [REG_W-1:0]  rd,
    input  logic              we,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_we
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data <= '0;
            wb_rd   <= '0;
            wb_we   <= 1'b0;
        end else if (load) begin
            wb_data <= data;
            wb_rd   <= rd;
            wb_we   <= we;
        end else begin
            // Stalled: data and rd hold, only the write enable is killed.
            wb_we <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage with req/ack data memory and timeout
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   br, alu, adder, wdata, rd     EX/MEM latch contents
//   mem_rd, mem_wr, reg_wr, mem_to_reg  EX/MEM control bits
//   dm_req, dm_we, dm_addr, dm_wdata    data-memory request side
//   dm_rdata, dm_ack              data-memory response side
//   stall                         freezes all upstream latches
//   pcsrc, br_target              branch redirect to fetch
//   wb_data, wb_rd, wb_we         MEM/WB register outputs
//   err                           sticky timeout flag
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] adder,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  rd,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              reg_wr,
    input  logic              mem_to_reg,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              stall,
    output logic              pcsrc,
    output logic [DATA_W-1:0] br_target,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_we,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    mem_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              access;
    logic              abort;
    logic [DATA_W-1:0] wb_data_nxt;

    always_comb begin
        access    = mem_rd | mem_wr;
        dm_req    = ~rst & (((state == IDLE) & access) | (state == WAIT));
        dm_we     = mem_wr;
        dm_addr   = {alu[DATA_W-1:2], 2'b00};
        dm_wdata  = wdata;
        abort     = dm_req & ~dm_ack & (cnt == CNT_W'(TIMEOUT - 1));
        stall     = dm_req & ~dm_ack & ~abort;
        pcsrc     = br & ~stall;
        br_target = adder;
        // A store wins over a simultaneous load, so load data is only
        // selected for a pure load; an aborted load writes back zero.
        if (mem_to_reg & mem_rd & ~mem_wr)
            wb_data_nxt = abort ? '0 : dm_rdata;
        else
            wb_data_nxt = alu;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (access & ~dm_ack & ~abort) state_nxt = WAIT;
            WAIT: if (dm_ack | abort)            state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The counter only runs while a request is stalled; every completion
    // (ack, abort or no request) returns it to zero so back-to-back
    // accesses each get the full TIMEOUT budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cnt <= '0;
        else if (stall) cnt <= cnt + 1'b1;
        else            cnt <= '0;
    end

    // abort already excludes dm_ack, so a simultaneous ack leaves err alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        err <= 1'b0;
        else if (abort) err <= 1'b1;
    end

    mem_wb_latch u_mem_wb_latch (
        .clk     (clk),
        .rst     (rst),
        .load    (~stall),
        .data    (wb_data_nxt),
        .rd      (rd),
        .we      (reg_wr),
        .wb_data (wb_data),
        .wb_rd   (wb_rd),
        .wb_we   (wb_we)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage (table, directed and random)
module tb_mem_stage;

    localparam int TO = 4;

    typedef struct {
        logic        br;
        logic [31:0] alu;
        logic [31:0] adder;
        logic [31:0] wdata;
        logic [5:0]  rd;
        logic        mrd;
        logic        mwr;
        logic        rw;
        logic        m2r;
        int          lat;     // request cycle in which ack arrives (> TO: never)
        logic [31:0] rdata;
    } op_t;

    typedef struct {
        op_t         op;
        logic [31:0] exp_data;
        int          exp_stalls;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br = 1'b0;
    logic [31:0] alu = '0, adder = '0, wdata = '0, dm_rdata = '0;
    logic [5:0]  rd = '0;
    logic        mem_rd = 1'b0, mem_wr = 1'b0, reg_wr = 1'b0, mem_to_reg = 1'b0;
    logic        dm_ack = 1'b0;
    logic        dm_req, dm_we, stall, pcsrc, wb_we, err;
    logic [31:0] dm_addr, dm_wdata, br_target, wb_data;
    logic [5:0]  wb_rd;

    int n_tests = 0;
    int n_fail  = 0;
    logic err_model = 1'b0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .br(br), .alu(alu), .adder(adder), .wdata(wdata),
        .rd(rd), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .mem_to_reg(mem_to_reg), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_ack(dm_ack), .stall(stall), .pcsrc(pcsrc), .br_target(br_target),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: ack at cycle lat completes the access; with no ack by
    // cycle TO the access is aborted at cycle TO and a load returns zero.
    task automatic model(input op_t o, output logic [31:0] exp_data, output int exp_stalls);
        logic aborted;
        aborted = (o.mrd | o.mwr) && (o.lat > TO);
        if (!(o.mrd | o.mwr)) exp_stalls = 0;
        else                  exp_stalls = (aborted ? TO : o.lat) - 1;
        if (o.m2r && o.mrd && !o.mwr) exp_data = aborted ? 32'h0 : o.rdata;
        else                          exp_data = o.alu;
    endtask

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic run_op(input op_t o, input logic [31:0] exp_data, input int exp_stalls);
        logic acc, st;
        acc = o.mrd | o.mwr;
        br = o.br; alu = o.alu; adder = o.adder; wdata = o.wdata; rd = o.rd;
        mem_rd = o.mrd; mem_wr = o.mwr; reg_wr = o.rw; mem_to_reg = o.m2r;
        for (int cyc = 1; cyc <= exp_stalls + 1; cyc++) begin
            dm_ack   = (cyc == o.lat);
            dm_rdata = (cyc == o.lat) ? o.rdata : $urandom;
            #3;
            st = (cyc <= exp_stalls);
            check("stall", 32'(stall), 32'(st));
            check("dm_req", 32'(dm_req), 32'(acc));
            check("pcsrc", 32'(pcsrc), 32'(o.br & ~st));
            check("br_target", br_target, o.adder);
            if (acc) begin
                check("dm_addr", dm_addr, {o.alu[31:2], 2'b00});
                check("dm_we", 32'(dm_we), 32'(o.mwr));
                check("dm_wdata", dm_wdata, o.wdata);
            end
            if (cyc > 1) check("wb_we_bubble", 32'(wb_we), 32'h0);
            @(posedge clk); #1;
        end
        if (acc && exp_stalls == TO - 1 && o.lat > TO) err_model = 1'b1;
        dm_ack = 1'b0;
        check("wb_data", wb_data, exp_data);
        check("wb_rd", 32'(wb_rd), 32'(o.rd));
        check("wb_we", 32'(wb_we), 32'(o.rw));
        check("err", 32'(err), 32'(err_model));
    endtask

    function automatic op_t mk(input logic b, input logic [31:0] a, input logic [31:0] ad,
                               input logic [31:0] wd, input logic [5:0] r, input logic mr,
                               input logic mw, input logic w, input logic m2,
                               input int l, input logic [31:0] rdt);
        op_t o;
        o.br = b; o.alu = a; o.adder = ad; o.wdata = wd; o.rd = r; o.mrd = mr;
        o.mwr = mw; o.rw = w; o.m2r = m2; o.lat = l; o.rdata = rdt;
        return o;
    endfunction

    initial begin
        vec_t vecs[7];
        op_t o;
        logic [31:0] ed;
        int es;

        vecs[0] = '{mk(0, 32'h1234, 0, 0, 5, 0, 0, 1, 0, 1, 0), 32'h1234, 0};
        vecs[1] = '{mk(0, 32'h102, 0, 0, 7, 1, 0, 1, 1, 3, 32'hDEADBEEF), 32'hDEADBEEF, 2};
        vecs[2] = '{mk(0, 32'h200, 0, 32'hCAFEF00D, 3, 0, 1, 0, 0, 1, 0), 32'h200, 0};
        vecs[3] = '{mk(1, 32'h10, 32'h400, 0, 2, 0, 0, 0, 0, 1, 0), 32'h10, 0};
        vecs[4] = '{mk(0, 32'h3FF, 0, 32'h77, 9, 1, 1, 1, 1, 2, 32'h55), 32'h3FF, 1};
        vecs[5] = '{mk(0, 32'h88, 0, 0, 4, 1, 0, 1, 0, 1, 32'h99), 32'h88, 0};
        vecs[6] = '{mk(1, 32'h44, 32'h800, 0, 6, 1, 0, 1, 1, 2, 32'h1111), 32'h1111, 1};

        // Reset state
        #3;
        check("rst_dm_req", 32'(dm_req), 32'h0);
        @(posedge clk); #1;
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_rd", 32'(wb_rd), 32'h0);
        check("rst_wb_we", 32'(wb_we), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].exp_data, vecs[i].exp_stalls);

        // Timeout: no ack ever; stall 3 cycles, abort on 4th, err sticky
        run_op(mk(1, 32'h300, 32'h500, 0, 8, 1, 0, 1, 1, 99, 0), 32'h0, TO - 1);
        check("err_set", 32'(err), 32'h1);
        run_op(vecs[1].op, vecs[1].exp_data, vecs[1].exp_stalls);
        run_op(vecs[2].op, vecs[2].exp_data, vecs[2].exp_stalls);
        check("err_sticky", 32'(err), 32'h1);

        // Ack on the last allowed cycle wins over abort
        run_op(mk(0, 32'h20, 0, 0, 1, 1, 0, 1, 1, TO, 32'hABCD), 32'hABCD, TO - 1);

        // Reset during the second wait cycle
        br = 0; alu = 32'h104; rd = 3; mem_rd = 1; mem_wr = 0; reg_wr = 1;
        mem_to_reg = 1; dm_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rstw_dm_req", 32'(dm_req), 32'h0);
        check("rstw_wb_we", 32'(wb_we), 32'h0);
        check("rstw_err", 32'(err), 32'h0);
        check("rstw_wb_data", wb_data, 32'h0);
        err_model = 1'b0;
        mem_rd = 0; reg_wr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #2;
        check("post_rst_stall", 32'(stall), 32'h0);
        check("post_rst_dm_req", 32'(dm_req), 32'h0);
        @(posedge clk); #1;
        run_op(vecs[1].op, vecs[1].exp_data, vecs[1].exp_stalls);

        // Random operations against the reference model
        for (int k = 0; k < 60; k++) begin
            o = mk($urandom_range(0, 1), $urandom, $urandom, $urandom,
                   6'($urandom), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                   $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(1, TO + 2), $urandom);
            model(o, ed, es);
            run_op(o, ed, es);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
